// File: rtl/dma_priority_logic.sv
// dma_priority_logic
//   Channel arbitration and bus-request stage of the DMA controller.
//   Forms effective requests from the DREQ pins, the mask register and the
//   software request register. It resolves fixed or rotating priority and
//   runs the HRQ/HLDA hold handshake with the CPU. It then drives one DACK
//   per channel.
//
// Ports
//   CLK           controller clock, rising edge
//   RESET         synchronous, active-high reset
//   DREQ          channel request pins (polarity per DREQ_LOW)
//   HLDA          hold acknowledge from CPU
//   MASK          1 = ignore hardware request of that channel
//   SWREQ         software requests, not masked
//   CTRL_DISABLE  1 = no new arbitration (IDLE -> REQ blocked)
//   ROTATE        0 = fixed priority, 1 = rotating priority
//   DREQ_LOW      1 = DREQ pins active-low
//   DACK_HIGH     1 = DACK active-high
//   SERVICE_DONE  one-cycle pulse, current service finished
//   HRQ           hold request to CPU
//   DACK          channel acknowledges
//   ACTIVE_CH     index of granted channel
//   GRANT_VALID   1 while a channel owns the bus
module dma_priority_logic #(
  parameter int CHANNELS = 4,
  parameter int CW       = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] DREQ,
  input  logic                HLDA,
  input  logic [CHANNELS-1:0] MASK,
  input  logic [CHANNELS-1:0] SWREQ,
  input  logic                CTRL_DISABLE,
  input  logic                ROTATE,
  input  logic                DREQ_LOW,
  input  logic                DACK_HIGH,
  input  logic                SERVICE_DONE,
  output logic                HRQ,
  output logic [CHANNELS-1:0] DACK,
  output logic [CW-1:0]       ACTIVE_CH,
  output logic                GRANT_VALID
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_top;
  logic [CW-1:0]       r_ch;
  logic                r_hrq;
  logic [CHANNELS-1:0] r_dack;
  logic [CW-1:0]       r_active_ch;
  logic                r_grant_valid;

  logic [CHANNELS-1:0] w_req;
  logic [CW-1:0]       w_top;
  logic [CW-1:0]       w_idx;
  logic [CW-1:0]       w_win;
  logic                w_found;
  logic                w_ch_load;
  logic                w_rotate;
  logic [CHANNELS-1:0] w_onehot;
  logic                w_hrq;
  logic [CHANNELS-1:0] w_dack;
  logic [CW-1:0]       w_active_ch;
  logic                w_grant_valid;

  assign w_req = ((DREQ ^ {CHANNELS{DREQ_LOW}}) & ~MASK) | SWREQ;
  assign w_top = ROTATE ? r_top : '0;

  // Scan from the priority pointer upward; CW-bit addition gives the
  // wrap-around for free because CHANNELS is a power of two.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_idx = w_top + CW'(i);
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ch_load = 1'b0;
    w_rotate  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((|w_req) && !CTRL_DISABLE) w_next = S_REQ;
      end
      S_REQ: begin
        if (HLDA) begin
          if (w_found) begin
            w_next    = S_GRANT;
            w_ch_load = 1'b1;
          end else begin
            w_next = S_RELEASE;
          end
        end
      end
      S_GRANT: begin
        // A done pulse coinciding with HLDA loss still counts as a
        // completed service; only the destination state differs.
        if (SERVICE_DONE) begin
          w_rotate = 1'b1;
          w_next   = HLDA ? S_RELEASE : S_IDLE;
        end else if (!HLDA) begin
          w_next = S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!HLDA) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_onehot[i] = (r_ch == CW'(i));
    end
  end

  // Outputs are a registered decode of the current state, so they follow
  // the state register by one edge.
  always_comb begin
    w_hrq         = (r_state == S_REQ) || (r_state == S_GRANT);
    w_grant_valid = (r_state == S_GRANT);
    w_active_ch   = '0;
    w_dack        = {CHANNELS{~DACK_HIGH}};
    if (r_state == S_GRANT) begin
      w_active_ch = r_ch;
      w_dack      = DACK_HIGH ? w_onehot : ~w_onehot;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_top         <= '0;
      r_ch          <= '0;
      r_hrq         <= 1'b0;
      r_dack        <= '1;
      r_active_ch   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ch_load) r_ch <= w_win;
      if (!ROTATE) begin
        r_top <= '0;
      end else if (w_rotate) begin
        r_top <= r_ch + 1'b1;
      end
      r_hrq         <= w_hrq;
      r_dack        <= w_dack;
      r_active_ch   <= w_active_ch;
      r_grant_valid <= w_grant_valid;
    end
  end

  assign HRQ         = r_hrq;
  assign DACK        = r_dack;
  assign ACTIVE_CH   = r_active_ch;
  assign GRANT_VALID = r_grant_valid;

endmodule

// File: tb/tb_dma_priority_logic.sv
// tb_dma_priority_logic
//   Directed bench for dma_priority_logic (CHANNELS=4) with hand-computed
//   expected values.
module tb_dma_priority_logic;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] MASK;
  logic [3:0] SWREQ;
  logic       CTRL_DISABLE;
  logic       ROTATE;
  logic       DREQ_LOW;
  logic       DACK_HIGH;
  logic       SERVICE_DONE;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] ACTIVE_CH;
  logic       GRANT_VALID;

  int errors = 0;
  int checks = 0;

  dma_priority_logic #(.CHANNELS(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (DREQ),
    .HLDA         (HLDA),
    .MASK         (MASK),
    .SWREQ        (SWREQ),
    .CTRL_DISABLE (CTRL_DISABLE),
    .ROTATE       (ROTATE),
    .DREQ_LOW     (DREQ_LOW),
    .DACK_HIGH    (DACK_HIGH),
    .SERVICE_DONE (SERVICE_DONE),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .ACTIVE_CH    (ACTIVE_CH),
    .GRANT_VALID  (GRANT_VALID)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET        = 1'b1;
    DREQ         = '0;
    HLDA         = 1'b0;
    MASK         = '0;
    SWREQ        = '0;
    CTRL_DISABLE = 1'b0;
    ROTATE       = 1'b0;
    DREQ_LOW     = 1'b0;
    DACK_HIGH    = 1'b0;
    SERVICE_DONE = 1'b0;
    tick;
    RESET = 1'b0;
  endtask

  // From IDLE/RELEASE with requests pending: wait for HRQ, return HLDA,
  // and stop once the grant outputs are visible.
  task automatic req_to_grant;
    int n;
    n = 0;
    while (!HRQ && n < 10) begin
      tick;
      n++;
    end
    check("hrq_wait", HRQ, 1);
    HLDA = 1'b1;
    tick;
    tick;
  endtask

  task automatic finish_service;
    logic [3:0] inact;
    inact = DACK_HIGH ? 4'b0000 : 4'b1111;
    SERVICE_DONE = 1'b1;
    tick;
    SERVICE_DONE = 1'b0;
    tick;
    check("rel_hrq", HRQ, 0);
    check("rel_dack", DACK, inact);
    check("rel_gv", GRANT_VALID, 0);
    HLDA = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rot_exp[6] = '{0, 1, 2, 3, 0, 1};

    do_reset;
    check("rst_hrq", HRQ, 0);
    check("rst_dack", DACK, 4'b1111);
    check("rst_ch", ACTIVE_CH, 0);
    check("rst_gv", GRANT_VALID, 0);

    // Fixed priority with exact latency checks
    DREQ = 4'b1010;
    tick;
    check("fix_hrq_k", HRQ, 0);
    tick;
    check("fix_hrq_k1", HRQ, 1);
    HLDA = 1'b1;
    tick;
    check("fix_gv_k", GRANT_VALID, 0);
    tick;
    check("fix_dack", DACK, 4'b1101);
    check("fix_ch", ACTIVE_CH, 1);
    check("fix_gv", GRANT_VALID, 1);
    check("fix_hrq", HRQ, 1);
    DREQ = 4'b1000;
    tick;
    check("fix_hold_dack", DACK, 4'b1101);
    finish_service;
    req_to_grant;
    check("fix_ch3", ACTIVE_CH, 3);
    check("fix_dack3", DACK, 4'b0111);
    finish_service;

    // Rotating priority: 0,1,2,3,0 then 1 shows top=1
    do_reset;
    ROTATE = 1'b1;
    DREQ   = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      req_to_grant;
      check($sformatf("rot_ch%0d", k), ACTIVE_CH, rot_exp[k]);
      finish_service;
    end

    // Mask / software request / polarity
    do_reset;
    DREQ_LOW  = 1'b1;
    DACK_HIGH = 1'b1;
    MASK      = 4'b0001;
    DREQ      = 4'b1110;
    repeat (4) tick;
    check("mask_hrq", HRQ, 0);
    check("mask_dack_idle", DACK, 4'b0000);
    SWREQ = 4'b0100;
    req_to_grant;
    check("sw_ch", ACTIVE_CH, 2);
    check("sw_dack", DACK, 4'b0100);
    finish_service;

    // CTRL_DISABLE and request withdrawn before HLDA
    do_reset;
    CTRL_DISABLE = 1'b1;
    DREQ         = 4'b0001;
    repeat (4) tick;
    check("dis_hrq", HRQ, 0);
    CTRL_DISABLE = 1'b0;
    tick;
    tick;
    check("en_hrq", HRQ, 1);
    DREQ = 4'b0000;
    HLDA = 1'b1;
    tick;
    tick;
    check("wd_hrq", HRQ, 0);
    check("wd_gv", GRANT_VALID, 0);
    check("wd_dack", DACK, 4'b1111);
    HLDA = 1'b0;
    repeat (3) tick;
    check("wd_idle_hrq", HRQ, 0);

    // HLDA lost mid-grant, then simultaneous done + HLDA fall
    do_reset;
    ROTATE = 1'b1;
    DREQ   = 4'b0001;
    req_to_grant;
    check("loss_ch0", ACTIVE_CH, 0);
    DREQ = 4'b0011;
    HLDA = 1'b0;
    tick;
    tick;
    check("loss_dack", DACK, 4'b1111);
    check("loss_hrq", HRQ, 0);
    check("loss_gv", GRANT_VALID, 0);
    req_to_grant;
    check("loss_norot", ACTIVE_CH, 0);
    SERVICE_DONE = 1'b1;
    HLDA         = 1'b0;
    tick;
    SERVICE_DONE = 1'b0;
    tick;
    check("sim_hrq", HRQ, 0);
    check("sim_gv", GRANT_VALID, 0);
    req_to_grant;
    check("sim_rot", ACTIVE_CH, 1);
    check("sim_dack", DACK, 4'b1101);

    // Reset during GRANT
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    check("gr_rst_hrq", HRQ, 0);
    check("gr_rst_dack", DACK, 4'b1111);
    check("gr_rst_gv", GRANT_VALID, 0);
    check("gr_rst_ch", ACTIVE_CH, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_priority_logic.md
# dma_priority_logic

Channel arbitration and bus-request stage of the DMA controller. Sits between the channel request pins (DREQ), the command/mask/request registers held in the datapath, and the timing-and-control sequencer. It resolves fixed or rotating priority among enabled requests and runs the HRQ/HLDA hold handshake with the CPU. It drives one DACK per channel and reports the granted channel to the rest of the controller.

## Interface
Parameters:
- CHANNELS, 4: number of DMA channels; must be a power of two ≥ 2.
- CW, $clog2(CHANNELS): width of the channel index.

Ports (one clock; reset is synchronous and active-high):
- CLK  input  1  controller clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- DREQ  input  CHANNELS  channel DMA requests; pin level, polarity set by DREQ_LOW.
- HLDA  input  1  hold acknowledge from CPU.
- MASK  input  CHANNELS  mask register; 1 = hardware request of that channel ignored.
- SWREQ  input  CHANNELS  software request register; active-high, not affected by MASK.
- CTRL_DISABLE  input  1  command bit 2; 1 = no new arbitration.
- ROTATE  input  1  command bit 4; 0 = fixed priority, 1 = rotating priority.
- DREQ_LOW  input  1  command bit 6; 1 = DREQ active-low.
- DACK_HIGH  input  1  command bit 7; 1 = DACK active-high.
- SERVICE_DONE  input  1  one-cycle pulse from timing-and-control: current service ended (TC, EOP, or end of single/demand burst).
- HRQ  output  1  hold request to CPU.
- DACK  output  CHANNELS  channel acknowledges, polarity per DACK_HIGH.
- ACTIVE_CH  output  CW  index of granted channel.
- GRANT_VALID  output  1  1 while a channel owns the bus (DACK asserted).

## Operation
- Effective request: req[i] = ((DREQ[i] ^ DREQ_LOW) & ~MASK[i]) | SWREQ[i].
- Priority pointer `top` (CW bits) = highest-priority channel. Fixed mode: top forced to 0, so channel 0 is highest and channel CHANNELS-1 is lowest. Rotating mode: after a completed service of channel n, top ← (n+1) mod CHANNELS, so n becomes lowest.
- Winner is the first set req bit scanning from top upward with wrap-around.
- FSM states:
  - IDLE: HRQ=0, DACK inactive. If any req and !CTRL_DISABLE, go to REQ.
  - REQ: HRQ=1. When HLDA=1, arbitrate on that cycle's req. With a winner, latch the channel and go to GRANT. With no req, go to RELEASE.
  - GRANT: HRQ=1, DACK[ch] active, GRANT_VALID=1, ACTIVE_CH=ch. On SERVICE_DONE, go to RELEASE and update top (rotating mode). If HLDA falls without SERVICE_DONE, go to IDLE (bus lost): DACK deasserted, HRQ=0, no rotation.
  - RELEASE: HRQ=0, DACK inactive. When HLDA=0, go to IDLE.
- Grant is not pre-empted: a higher-priority request arriving during GRANT waits for RELEASE→IDLE→REQ.
- CTRL_DISABLE affects only IDLE→REQ. A grant in progress completes normally.
- Changes to MASK, DREQ or SWREQ during GRANT do not remove DACK; timing-and-control ends the service.
- Simultaneous SERVICE_DONE and HLDA fall in GRANT: treat as completed service (rotate), go to IDLE.

## Timing
- All outputs are registered.
- Reset values: HRQ=0, DACK=all ones (inactive for the command register reset value DACK_HIGH=0), ACTIVE_CH=0, GRANT_VALID=0, top=0, state=IDLE.
- After reset, the inactive DACK level is ~DACK_HIGH on every bit.
- req seen in IDLE at edge k: HRQ=1 after edge k+1.
- HLDA sampled 1 in REQ at edge k: DACK/GRANT_VALID/ACTIVE_CH valid after edge k+1. HRQ stays 1.
- SERVICE_DONE at edge k: HRQ=0, DACK inactive, GRANT_VALID=0 after edge k+1. top updated on the same edge.
- Minimum req→DACK latency is 3 cycles with HLDA returned in 1 cycle.
- RESET asserted in any state: all outputs return to reset values on the next edge. No partial handshake is retained.

## Test plan
- Fixed priority: ROTATE=0, DREQ=4'b1010, HLDA returned 1 cycle after HRQ → DACK=4'b1101 (ch1, active-low), ACTIVE_CH=1. After SERVICE_DONE and HLDA low, the re-request grants ch3.
- Rotating: ROTATE=1, DREQ=4'b1111 held, four services completed → grant order 0,1,2,3,0. top=1 after the fifth.
- Mask/software/polarity: MASK=4'b0001, DREQ_LOW=1, DREQ pin=4'b1110 → grant ch0 is blocked. Setting SWREQ=4'b0100 → grant ch2 while ch0 stays masked. With DACK_HIGH=1 → DACK=4'b0100.
- Handshake edges: CTRL_DISABLE=1 with requests → HRQ stays 0. A request withdrawn before HLDA → RELEASE, HRQ=0, no DACK.
- HLDA dropped mid-GRANT → DACK inactive and HRQ=0 next cycle, top unchanged. Simultaneous SERVICE_DONE+HLDA fall → top rotates.
- RESET asserted in GRANT → HRQ=0, DACK=4'b1111, GRANT_VALID=0, ACTIVE_CH=0 after one edge.
